// File: rtl/fpmul_share_arb.sv
// Round-robin scheduler sharing one fixed-latency FP64 multiplier between NREQ requesters.
// A tag shift register follows every issued operand pair so each product returns to its owner.
module fpmul_share_arb #(
  parameter int NREQ   = 4,
  parameter int LAT    = 6,
  parameter int MAXOUT = 2
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [64*NREQ-1:0]   req_a,
  input  logic [64*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 hold,
  output logic [63:0]          mul_a,
  output logic [63:0]          mul_b,
  input  logic [63:0]          mul_p,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [63:0]          rsp_data,
  output logic                 idle
);

  // Handshake: an operand pair moves when req_valid[i] & req_ready[i] at a rising edge.
  // req_ready is a pure function of current state and req_valid/hold, at most one bit high.
  // Results have no ready: rsp_valid[i] is a one-cycle strobe the requester must take.

  localparam logic [2:0] MAXOUT_C = 3'(MAXOUT);
  localparam logic [2:0] LAST_ID  = 3'(NREQ - 1);

  logic [2:0]      ptr;
  logic [2:0]      cnt     [NREQ];
  logic [2:0]      cnt_nxt [NREQ];
  logic [NREQ-1:0] eligible;
  logic            gnt_any;
  logic [2:0]      gnt_id;
  logic [63:0]     sel_a;
  logic [63:0]     sel_b;
  logic [LAT:0]    tag_v;
  logic [LAT:0]    tag_v_nxt;
  logic [2:0]      tag_id  [LAT+1];
  logic            idle_nxt;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      eligible[i] = req_valid[i] & (cnt[i] < MAXOUT_C) & ~hold;
    end
  end

  // Rotating search starting at ptr; the first eligible requester found wins.
  always_comb begin
    int c;
    gnt_any = 1'b0;
    gnt_id  = 3'd0;
    c       = 0;
    for (int j = 0; j < NREQ; j++) begin
      c = int'(ptr) + j;
      if (c >= NREQ) c = c - NREQ;
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_any && (i == c) && eligible[i]) begin
          gnt_any = 1'b1;
          gnt_id  = 3'(i);
        end
      end
    end
  end

  always_comb begin
    sel_a = 64'd0;
    sel_b = 64'd0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = gnt_any && (gnt_id == 3'(i));
      if (req_ready[i]) begin
        sel_a = req_a[64*i +: 64];
        sel_b = req_b[64*i +: 64];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      rsp_valid[i] = tag_v[LAT] && (tag_id[LAT] == 3'(i));
    end
  end

  assign rsp_data = mul_p;

  // A grant and a return for the same requester in one cycle cancel out.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      case ({req_ready[i], rsp_valid[i]})
        2'b10:   cnt_nxt[i] = cnt[i] + 3'd1;
        2'b01:   cnt_nxt[i] = cnt[i] - 3'd1;
        default: cnt_nxt[i] = cnt[i];
      endcase
    end
  end

  always_comb begin
    tag_v_nxt = {tag_v[LAT-1:0], gnt_any};
    idle_nxt  = ~|tag_v_nxt;
    for (int i = 0; i < NREQ; i++) begin
      if (cnt_nxt[i] != 3'd0) idle_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr   <= 3'd0;
      mul_a <= 64'd0;
      mul_b <= 64'd0;
      tag_v <= '0;
      idle  <= 1'b1;
      for (int j = 0; j <= LAT; j++) tag_id[j] <= 3'd0;
      for (int i = 0; i < NREQ; i++) cnt[i] <= 3'd0;
    end else begin
      if (gnt_any) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
        ptr   <= (gnt_id == LAST_ID) ? 3'd0 : gnt_id + 3'd1;
      end
      tag_v     <= tag_v_nxt;
      tag_id[0] <= gnt_id;
      for (int j = 1; j <= LAT; j++) tag_id[j] <= tag_id[j-1];
      for (int i = 0; i < NREQ; i++) cnt[i] <= cnt_nxt[i];
      idle <= idle_nxt;
    end
  end

endmodule

// File: tb/tb_fpmul_share_arb.sv
// Randomized bench for fpmul_share_arb: a transaction-level model predicts grants,
// return strobes, products and idle every cycle.
module tb_fpmul_share_arb;

  localparam int NREQ   = 4;
  localparam int LAT    = 6;
  localparam int MAXOUT = 2;

  localparam int M_MANUAL = 0;
  localparam int M_FULL   = 1;
  localparam int M_RANDOM = 2;

  logic                 clk;
  logic                 nrst;
  logic [NREQ-1:0]      req_valid;
  logic [64*NREQ-1:0]   req_a;
  logic [64*NREQ-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 hold;
  logic [63:0]          mul_a;
  logic [63:0]          mul_b;
  logic [63:0]          mul_p;
  logic [NREQ-1:0]      rsp_valid;
  logic [63:0]          rsp_data;
  logic                 idle;

  fpmul_share_arb #(.NREQ(NREQ), .LAT(LAT), .MAXOUT(MAXOUT)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .hold      (hold),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .idle      (idle)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] fmul(input logic [63:0] a, input logic [63:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  // Stand-in for the shared multiplier: LAT-cycle pipeline, reset shared with the arbiter.
  logic [63:0] p_pipe [LAT];
  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int j = 0; j < LAT; j++) p_pipe[j] <= 64'd0;
    end else begin
      p_pipe[0] <= fmul(mul_a, mul_b);
      for (int j = 1; j < LAT; j++) p_pipe[j] <= p_pipe[j-1];
    end
  end
  assign mul_p = p_pipe[LAT-1];

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  int          id_q[$];
  int          gcyc_q[$];
  int          cyc;
  int          mptr;
  int          gk;
  logic [63:0] exp_mul_a;
  logic [63:0] exp_mul_b;
  int          checks;
  int          failures;
  int          mode;
  logic [NREQ-1:0] vmask;
  logic        dir_chk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    id_q.delete();
    gcyc_q.delete();
    mptr      = 0;
    exp_mul_a = 64'd0;
    exp_mul_b = 64'd0;
    gk        = -1;
  endtask

  // Every op in the queue was granted in an earlier cycle and has not yet returned,
  // so the per-requester outstanding count is simply how often its id appears.
  task automatic check_cycle();
    int cnt [NREQ];
    int k;
    logic [NREQ-1:0] exp_ready;
    logic [NREQ-1:0] exp_rsp;
    for (int i = 0; i < NREQ; i++) cnt[i] = 0;
    foreach (id_q[n]) cnt[id_q[n]]++;
    gk = -1;
    if (nrst && !hold) begin
      for (int j = 0; j < NREQ; j++) begin
        k = (mptr + j) % NREQ;
        if (gk < 0 && req_valid[k] && cnt[k] < MAXOUT) gk = k;
      end
    end
    exp_ready = '0;
    if (gk >= 0) exp_ready[gk] = 1'b1;
    exp_rsp = '0;
    if (id_q.size() > 0 && gcyc_q[0] + LAT + 1 == cyc) exp_rsp[id_q[0]] = 1'b1;
    check("req_ready", 64'(req_ready), 64'(exp_ready));
    check("rsp_valid", 64'(rsp_valid), 64'(exp_rsp));
    if (exp_rsp != '0) begin
      check("rsp_data", rsp_data, exp_q[0]);
      if (dir_chk) check("rsp_data_const", rsp_data, 64'h4008000000000000);
    end
    check("idle", 64'(idle), 64'(exp_q.size() == 0));
    check("mul_a", mul_a, exp_mul_a);
    check("mul_b", mul_b, exp_mul_b);
  endtask

  task automatic commit();
    logic [63:0] a;
    logic [63:0] b;
    if (nrst) begin
      if (id_q.size() > 0 && gcyc_q[0] + LAT + 1 == cyc) begin
        void'(exp_q.pop_front());
        void'(id_q.pop_front());
        void'(gcyc_q.pop_front());
      end
      if (gk >= 0) begin
        a = req_a[64*gk +: 64];
        b = req_b[64*gk +: 64];
        exp_q.push_back(fmul(a, b));
        id_q.push_back(gk);
        gcyc_q.push_back(cyc);
        exp_mul_a = a;
        exp_mul_b = b;
        mptr = (gk + 1) % NREQ;
      end
    end
    cyc++;
  endtask

  // ---------------- driver ----------------
  function automatic logic [63:0] rand_op();
    real v;
    v = $itor($urandom_range(1, 4000)) / 16.0;
    if ($urandom_range(0, 1) == 1) v = -v;
    return $realtobits(v);
  endfunction

  task automatic drive_next();
    logic granted;
    for (int i = 0; i < NREQ; i++) begin
      granted = (gk == i);
      case (mode)
        M_FULL:   req_valid[i] = vmask[i];
        M_RANDOM: if (!req_valid[i] || granted) req_valid[i] = ($urandom_range(0, 99) < 60);
        default:  if (granted) req_valid[i] = 1'b0;
      endcase
      if (granted || !req_valid[i]) begin
        req_a[64*i +: 64] = rand_op();
        req_b[64*i +: 64] = rand_op();
      end
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      check_cycle();
      @(posedge clk);
      commit();
      #1;
      drive_next();
    end
  endtask

  task automatic drain();
    mode = M_MANUAL;
    req_valid = '0;
    hold = 1'b0;
    step(LAT + 4);
  endtask

  // ---------------- scenarios ----------------
  initial begin
    nrst = 1'b0; hold = 1'b0; req_valid = '0; req_a = '0; req_b = '0;
    mode = M_MANUAL; vmask = '0; dir_chk = 1'b0;
    checks = 0; failures = 0; cyc = 0;
    model_reset();
    step(2);
    nrst = 1'b1;

    // single op: 1.5 * 2.0 from requester 0
    req_valid = 4'b0001;
    req_a[63:0] = 64'h3FF8000000000000;
    req_b[63:0] = 64'h4000000000000000;
    dir_chk = 1'b1;
    step(12);
    dir_chk = 1'b0;

    // all four requesters continuously valid
    mode = M_FULL; vmask = 4'b1111;
    step(16);
    drain();

    // one requester alone saturates its outstanding cap
    mode = M_FULL; vmask = 4'b0010;
    step(20);
    drain();

    // hold with ops in flight, then resume
    mode = M_FULL; vmask = 4'b1111;
    step(3);
    hold = 1'b1;
    step(10);
    hold = 1'b0;
    step(6);
    drain();

    // asynchronous reset with ops in flight
    mode = M_FULL; vmask = 4'b1111;
    step(4);
    nrst = 1'b0;
    mode = M_MANUAL;
    req_valid = '0;
    model_reset();
    step(3);
    nrst = 1'b1;
    mode = M_FULL; vmask = 4'b1111;
    step(6);
    drain();

    // random traffic with occasional hold toggling
    mode = M_RANDOM;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 19) == 0) hold = ~hold;
      step(1);
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
